// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the
// sequential execute unit.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_DZ    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide over
// a {hi, lo} register pair, one step per cycle for WIDTH cycles.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             mode_q, mode_d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // hi holds the accumulator (MUL) or partial remainder (DIV); lo holds
    // the multiplier bits still to consume or the dividend shifting into quotient
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        mode_d    = mode_q;
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, opb_q};

        if (start) begin
            hi_d   = '0;
            lo_d   = op_a;
            opb_d  = op_b;
            cnt_d  = CW'(WIDTH - 1);
            run_d  = 1'b1;
            mode_d = mode;
        end else if (run_q) begin
            if (mode_q == MODE_MUL) begin
                {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
            end else if (!trial[WIDTH]) begin
                hi_d = trial[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            mode_q <= MODE_MUL;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opb_q  <= opb_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            mode_q <= mode_d;
        end
    end

    // The final step's result is exported combinationally so the caller can
    // capture it on the same edge that ends the operation.
    assign done    = run_q && (cnt_q == '0);
    assign hi_next = hi_d;
    assign lo_next = lo_d;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked execute unit: single-cycle ADD/SUB, iterative MUL/DIV through
// muldiv_iter, with registered results and flags held until consumed.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_opcode,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             md_start;
    logic             md_mode;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .mode    (md_mode),
        .op_a    (in_op1),
        .op_b    (in_op2),
        .done    (md_done),
        .hi_next (md_hi),
        .lo_next (md_lo)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        md_start    = 1'b0;
        md_mode     = MODE_MUL;
        add_full    = {1'b0, in_op1} + {1'b0, in_op2};
        sub_full    = {1'b0, in_op1} - {1'b0, in_op2};

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (in_opcode)
                        OP_ADD: begin
                            result_d           = add_full[WIDTH-1:0];
                            result_hi_d        = '0;
                            flags_d            = '0;
                            flags_d[FLG_CARRY] = add_full[WIDTH];
                            flags_d[FLG_ZERO]  = ~|add_full[WIDTH-1:0];
                            state_d            = ST_DONE;
                        end
                        OP_SUB: begin
                            result_d           = sub_full[WIDTH-1:0];
                            result_hi_d        = '0;
                            flags_d            = '0;
                            flags_d[FLG_CARRY] = sub_full[WIDTH];
                            flags_d[FLG_ZERO]  = ~|sub_full[WIDTH-1:0];
                            state_d            = ST_DONE;
                        end
                        OP_MUL: begin
                            md_start = 1'b1;
                            md_mode  = MODE_MUL;
                            state_d  = ST_MUL;
                        end
                        default: begin
                            if (in_op2 == '0) begin
                                result_d        = '1;
                                result_hi_d     = in_op1;
                                flags_d         = '0;
                                flags_d[FLG_DZ] = 1'b1;
                                state_d         = ST_DONE;
                            end else begin
                                md_start = 1'b1;
                                md_mode  = MODE_DIV;
                                state_d  = ST_DIV;
                            end
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (md_done) begin
                    result_d          = md_lo;
                    result_hi_d       = md_hi;
                    flags_d           = '0;
                    flags_d[FLG_OVF]  = |md_hi;
                    flags_d[FLG_ZERO] = ~|md_lo;
                    state_d           = ST_DONE;
                end
            end
            ST_DIV: begin
                if (md_done) begin
                    result_d          = md_lo;
                    result_hi_d       = md_hi;
                    flags_d           = '0;
                    flags_d[FLG_ZERO] = ~|md_lo;
                    state_d           = ST_DONE;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=8 with
// hand-computed expected results, latencies and flags.
module tb_alu_seq_core;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_opcode;
    logic [W-1:0] in_op1;
    logic [W-1:0] in_op2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;
    logic         busy;

    int passed;
    int total;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Issue one instruction, measure latency to out_valid, check outputs, then consume.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] exp_res,
                                 input logic [W-1:0] exp_hi, input logic [3:0] exp_flags);
        int lat;
        @(negedge clk);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_op1    = a;
        in_op2    = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        end while (!out_valid && lat < 40);
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " result"}, 32'(result), 32'(exp_res));
        checkOutput({tag, " result_hi"}, 32'(result_hi), 32'(exp_hi));
        checkOutput({tag, " flags"}, 32'(flags), 32'(exp_flags));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        passed    = 0;
        total     = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 2'd0;
        in_op1    = '0;
        in_op2    = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset result_hi", 32'(result_hi), 32'd0);
        checkOutput("reset flags", 32'(flags), 32'd0);
        reset = 1'b1;

        applyStimulus("add200+100", 2'd0, 8'd200, 8'd100, 1, 8'd44, 8'd0, 4'b0010);
        applyStimulus("sub5-7", 2'd1, 8'd5, 8'd7, 1, 8'd254, 8'd0, 4'b0010);
        applyStimulus("sub9-9", 2'd1, 8'd9, 8'd9, 1, 8'd0, 8'd0, 4'b0001);
        applyStimulus("mul16x16", 2'd2, 8'd16, 8'd16, 9, 8'd0, 8'd1, 4'b0101);
        applyStimulus("mul15x17", 2'd2, 8'd15, 8'd17, 9, 8'd255, 8'd0, 4'b0000);
        applyStimulus("mul255x255", 2'd2, 8'd255, 8'd255, 9, 8'd1, 8'd254, 4'b0100);
        applyStimulus("div100/7", 2'd3, 8'd100, 8'd7, 9, 8'd14, 8'd2, 4'b0000);
        applyStimulus("div7/100", 2'd3, 8'd7, 8'd100, 9, 8'd0, 8'd7, 4'b0001);
        applyStimulus("div55/0", 2'd3, 8'd55, 8'd0, 1, 8'd255, 8'd55, 4'b1000);

        // Backpressure: ADD 3+4 completes, SUB 10-3 waits behind a stalled consumer.
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 2'd0;
        in_op1    = 8'd3;
        in_op2    = 8'd4;
        @(posedge clk);
        #1;
        in_opcode = 2'd1;
        in_op1    = 8'd10;
        in_op2    = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp result", 32'(result), 32'd7);
            checkOutput("bp flags", 32'(flags), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp post in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp post out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp second out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp second result", 32'(result), 32'd7);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset during the fourth MUL iteration aborts with no output.
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 2'd2;
        in_op1    = 8'd200;
        in_op2    = 8'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort busy before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort result", 32'(result), 32'd0);
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 2'd0;
        in_op1    = 8'd9;
        in_op2    = 8'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("in reset ignored", 32'(out_valid), 32'd0);
        reset = 1'b1;
        lat = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        checkOutput("abort no late output", 32'(lat), 32'd0);
        applyStimulus("add1+1", 2'd0, 8'd1, 8'd1, 1, 8'd2, 8'd0, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
